mat3_mul_q16: RTL and testbench
===============================

Name: mat3_mul_q16

Overview:
- Sequential 3x3 signed fixed-point matrix multiplier, C = A x B, with a start/done handshake.
- Default format is Q16.16.
- Companion to the 3x3 inverse core. Its inverse output feeds back in as B to reconstruct A x A^-1, the identity, for in-system self-check. It also serves downstream kinematics chains.
- One time-multiplexed signed multiplier; one MAC per cycle.

Parameters:
- WIDTH, 32, operand/result width in bits (signed two's complement).
- FRAC, 16, fractional bits; product rescaled by arithmetic shift right FRAC.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- start  in  1  request; accepted only in IDLE
- A11..A33  in  WIDTH each (9 ports)  matrix A, row-major, Q16.16
- B11..B33  in  WIDTH each (9 ports)  matrix B, row-major, Q16.16
- busy  out  1  high from accepted start until done cycle inclusive
- done  out  1  one-cycle pulse, C valid
- ovf  out  1  any element saturated this operation (optional feature)
- C11..C33  out  WIDTH each (9 ports)  result matrix, registered, row-major

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE, busy=0, done=0, ovf=0, all Cij=0, counters and accumulator cleared. Reset mid-operation aborts immediately; no done pulse; C reads 0.
- FSM: IDLE -> MAC -> DONE -> IDLE.
- IDLE:
  - start=1 at edge: latch all 18 operands into internal registers; clear i, j, k and accumulator; busy=1; go to MAC.
  - Inputs may change freely after the accepting edge.
- MAC: one product per cycle.
  - prod = A[i][k]*B[k][j], full 2*WIDTH signed; acc += prod. acc is 2*WIDTH+2 bits.
  - When k=2: result = (acc+prod) >>> FRAC (arithmetic, truncation toward -inf), low WIDTH bits written to C[i][j]; acc cleared.
  - Order: k fastest, then j, then i.
  - 27 MAC cycles total; after (i,j,k)=(2,2,2) go to DONE.
- DONE: done=1, busy=1 for exactly one cycle; then IDLE with busy=0.
- Latency: done high in the 28th cycle after the accepting edge; back-to-back start accepted the cycle after done.
- start while busy (MAC or DONE) is ignored, not queued.
- C registers hold the last result until the next operation writes them. Elements update progressively during MAC; C is valid only at/after done.
- ovf cleared on accepted start.

Optional Feature:
- Macro MAT3_MUL_SAT_EN.
- Defined:
  - Each shifted sum is checked against the signed WIDTH range.
  - Out-of-range values clamp to 0x7FFFFFFF / 0x80000000.
  - ovf is set (sticky until the next accepted start).
- Undefined: low WIDTH bits taken (wrap-around); ovf tied 0; no comparators synthesized.

Test Plan:
- Identity x identity (diagonal 0x00010000, off-diagonal 0), start for 1 cycle -> done at cycle 28 after accept; Cii=0x00010000, off-diagonal 0; busy high for exactly 28 cycles.
- A=diag(2.0,4.0,0.5) (0x20000, 0x40000, 0x8000), B=diag(0.5,0.25,2.0) -> C=identity. This is the inverse self-check.
- A all 1.5 (0x18000), B all -2.0 (0xFFFE0000) -> every Cij = -9.0 = 0xFFF70000; A and B driven to garbage the cycle after accept -> result unchanged.
- start held high continuously, identity inputs -> one operation per 29 cycles; no start accepted during busy; done pulses exactly one cycle each.
- Reset mid-operation: rst_n=0 at MAC cycle 10 -> next cycle busy=0, done=0, all C=0; no done pulse later; a fresh start completes normally.
- A all 0x7FFF0000, B all 0x00020000:
  - With MAT3_MUL_SAT_EN: Cij=0x7FFFFFFF, ovf=1 at done.
  - Without MAT3_MUL_SAT_EN: Cij=0xFFFA0000 (wrapped), ovf=0.

Source files
------------

// File: rtl/mat3_mul_q16_if.sv
// mat3_mul_q16_if: start/done handshake, operand matrices A and B, and result
// matrix C for the 3x3 fixed-point multiplier. All matrices are row-major,
// WIDTH-bit signed two's complement.
//   slave  : the multiplier side (takes start/A/B, drives busy/done/ovf/C)
//   master : the requester side (drives start/A/B, observes busy/done/ovf/C)
interface mat3_mul_q16_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             busy;
    logic             done;
    logic             ovf;
    logic [WIDTH-1:0] A11, A12, A13, A21, A22, A23, A31, A32, A33;
    logic [WIDTH-1:0] B11, B12, B13, B21, B22, B23, B31, B32, B33;
    logic [WIDTH-1:0] C11, C12, C13, C21, C22, C23, C31, C32, C33;

    modport slave (
        input  start,
        input  A11, A12, A13, A21, A22, A23, A31, A32, A33,
        input  B11, B12, B13, B21, B22, B23, B31, B32, B33,
        output busy, done, ovf,
        output C11, C12, C13, C21, C22, C23, C31, C32, C33
    );

    modport master (
        output start,
        output A11, A12, A13, A21, A22, A23, A31, A32, A33,
        output B11, B12, B13, B21, B22, B23, B31, B32, B33,
        input  busy, done, ovf,
        input  C11, C12, C13, C21, C22, C23, C31, C32, C33
    );
endinterface

// File: rtl/mat3_mul_q16.sv
// mat3_mul_q16: sequential 3x3 signed fixed-point matrix multiply C = A x B.
// One shared signed multiplier, one multiply-accumulate per cycle, 27 MAC
// cycles per operation followed by a single done cycle.
// Ports:
//   clk   : clock, all logic on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : mat3_mul_q16_if.slave (start, A11..A33, B11..B33 in;
//           busy, done, ovf, C11..C33 out)
// Optional feature: define MAT3_MUL_SAT_EN to clamp each result element to
// the signed WIDTH range and raise a sticky ovf; otherwise results wrap and
// ovf is tied low.
module mat3_mul_q16 #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned FRAC  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    mat3_mul_q16_if.slave     bus
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned AW = 2 * WIDTH + 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;

    logic [8:0][WIDTH-1:0] a_in, b_in;
    logic [8:0][WIDTH-1:0] a_q, a_d;
    logic [8:0][WIDTH-1:0] b_q, b_d;
    logic [8:0][WIDTH-1:0] c_q, c_d;
    logic [1:0]            i_q, i_d, j_q, j_d, k_q, k_d;
    logic signed [AW-1:0]  acc_q, acc_d;

    logic                  accept;
    logic                  last_mac;
    logic [3:0]            a_idx, b_idx, c_idx;
    logic signed [WIDTH-1:0] a_sel, b_sel;
    logic signed [PW-1:0]  prod_w;
    logic signed [AW-1:0]  sum_w;
    logic signed [AW-1:0]  shifted_w;
    logic [WIDTH-1:0]      res_w;

    // Flatten the interface operands, index r*3+c
    assign a_in = {bus.A33, bus.A32, bus.A31, bus.A23, bus.A22, bus.A21, bus.A13, bus.A12, bus.A11};
    assign b_in = {bus.B33, bus.B32, bus.B31, bus.B23, bus.B22, bus.B21, bus.B13, bus.B12, bus.B11};

    assign accept   = (state_q == ST_IDLE) && bus.start;
    assign last_mac = (i_q == 2'd2) && (j_q == 2'd2) && (k_q == 2'd2);

    // Shared multiplier: A[i][k] * B[k][j]
    assign a_idx  = 4'(i_q) * 4'd3 + 4'(k_q);
    assign b_idx  = 4'(k_q) * 4'd3 + 4'(j_q);
    assign c_idx  = 4'(i_q) * 4'd3 + 4'(j_q);
    assign a_sel  = a_q[a_idx];
    assign b_sel  = b_q[b_idx];
    assign prod_w = PW'(a_sel) * PW'(b_sel);
    assign sum_w  = acc_q + AW'(prod_w);
    assign shifted_w = sum_w >>> FRAC;

`ifdef MAT3_MUL_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic ovf_q, ovf_d;
    logic elem_ovf;
    logic [AW-WIDTH:0] top_bits;

    // In range only when every bit above the result sign bit matches it
    assign top_bits = shifted_w[AW-1:WIDTH-1];
    assign elem_ovf = !((&top_bits) || !(|top_bits));
    assign res_w    = elem_ovf ? (shifted_w[AW-1] ? SAT_MIN : SAT_MAX) : WIDTH'(shifted_w);

    // Sticky overflow, cleared by an accepted start
    always_comb begin
        ovf_d = ovf_q;
        if (accept) begin
            ovf_d = 1'b0;
        end else if ((state_q == ST_MAC) && (k_q == 2'd2) && elem_ovf) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign res_w   = WIDTH'(shifted_w);
    assign bus.ovf = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_MAC;
            ST_MAC:  if (last_mac)  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs, computed from the next state so the flops line up with it
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // Datapath next state: operand capture, loop counters, accumulator, C writes
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        c_d   = c_q;
        i_d   = i_q;
        j_d   = j_q;
        k_d   = k_q;
        acc_d = acc_q;
        if (accept) begin
            a_d   = a_in;
            b_d   = b_in;
            i_d   = 2'd0;
            j_d   = 2'd0;
            k_d   = 2'd0;
            acc_d = '0;
        end else if (state_q == ST_MAC) begin
            if (k_q == 2'd2) begin
                c_d[c_idx] = res_w;
                acc_d      = '0;
                k_d        = 2'd0;
                if (j_q == 2'd2) begin
                    j_d = 2'd0;
                    i_d = (i_q == 2'd2) ? 2'd0 : i_q + 2'd1;
                end else begin
                    j_d = j_q + 2'd1;
                end
            end else begin
                acc_d = sum_w;
                k_d   = k_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            i_q    <= 2'd0;
            j_q    <= 2'd0;
            k_q    <= 2'd0;
            acc_q  <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            a_q    <= a_d;
            b_q    <= b_d;
            c_q    <= c_d;
            i_q    <= i_d;
            j_q    <= j_d;
            k_q    <= k_d;
            acc_q  <= acc_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.C11  = c_q[0];
    assign bus.C12  = c_q[1];
    assign bus.C13  = c_q[2];
    assign bus.C21  = c_q[3];
    assign bus.C22  = c_q[4];
    assign bus.C23  = c_q[5];
    assign bus.C31  = c_q[6];
    assign bus.C32  = c_q[7];
    assign bus.C33  = c_q[8];

endmodule

// File: tb/tb_mat3_mul_q16.sv
// Bench for mat3_mul_q16: directed matrices, a matrix-product model that
// tracks busy/done/C/ovf every cycle, plus literal expectations.
module tb_mat3_mul_q16;

    typedef logic [8:0][31:0] mat_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    mat3_mul_q16_if #(.WIDTH(32)) bus ();

    mat3_mul_q16 #(.WIDTH(32), .FRAC(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference product: exact sum of products, scaled down, then wrapped or clamped
    function automatic mat_t matmul(input mat_t a, input mat_t b, output logic o);
        mat_t r;
        logic signed [65:0] s;
        logic signed [65:0] sh;
        o = 1'b0;
        for (int row = 0; row < 3; row++) begin
            for (int col = 0; col < 3; col++) begin
                s = '0;
                for (int k = 0; k < 3; k++) begin
                    s = s + 66'($signed(a[row*3+k])) * 66'($signed(b[k*3+col]));
                end
                sh = s >>> 16;
`ifdef MAT3_MUL_SAT_EN
                if (sh > 66'sd2147483647) begin
                    r[row*3+col] = 32'h7FFFFFFF;
                    o = 1'b1;
                end else if (sh < -66'sd2147483648) begin
                    r[row*3+col] = 32'h80000000;
                    o = 1'b1;
                end else begin
                    r[row*3+col] = sh[31:0];
                end
`else
                r[row*3+col] = sh[31:0];
`endif
            end
        end
        return r;
    endfunction

    function automatic mat_t fill(input logic [31:0] v);
        mat_t m;
        for (int n = 0; n < 9; n++) m[n] = v;
        return m;
    endfunction

    function automatic mat_t diag(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        mat_t m;
        m    = '0;
        m[0] = d0;
        m[4] = d1;
        m[8] = d2;
        return m;
    endfunction

    task automatic drive_ab(input mat_t a, input mat_t b);
        bus.A11 = a[0]; bus.A12 = a[1]; bus.A13 = a[2];
        bus.A21 = a[3]; bus.A22 = a[4]; bus.A23 = a[5];
        bus.A31 = a[6]; bus.A32 = a[7]; bus.A33 = a[8];
        bus.B11 = b[0]; bus.B12 = b[1]; bus.B13 = b[2];
        bus.B21 = b[3]; bus.B22 = b[4]; bus.B23 = b[5];
        bus.B31 = b[6]; bus.B32 = b[7]; bus.B33 = b[8];
    endtask

    function automatic mat_t cur_a();
        return {bus.A33, bus.A32, bus.A31, bus.A23, bus.A22, bus.A21, bus.A13, bus.A12, bus.A11};
    endfunction

    function automatic mat_t cur_b();
        return {bus.B33, bus.B32, bus.B31, bus.B23, bus.B22, bus.B21, bus.B13, bus.B12, bus.B11};
    endfunction

    function automatic mat_t cur_c();
        return {bus.C33, bus.C32, bus.C31, bus.C23, bus.C22, bus.C21, bus.C13, bus.C12, bus.C11};
    endfunction

    // Cycle-level model: an accepted start makes the block busy for 28 cycles,
    // the last of which is done and publishes the product of the captured operands.
    int   rem;
    mat_t c_exp, c_pend;
    logic ovf_exp, ovf_pend;

    initial begin
        rem      = 0;
        c_exp    = '0;
        c_pend   = '0;
        ovf_exp  = 1'b0;
        ovf_pend = 1'b0;
    end

    always @(posedge clk) begin
        mat_t c_act;
        logic o;
        if (!rst_n) begin
            rem     = 0;
            c_exp   = '0;
            ovf_exp = 1'b0;
        end else if (rem == 0 && bus.start) begin
            rem      = 28;
            c_pend   = matmul(cur_a(), cur_b(), o);
            ovf_pend = o;
            ovf_exp  = 1'b0;
        end else if (rem > 0) begin
            rem = rem - 1;
        end
        if (rem == 1) begin
            c_exp   = c_pend;
            ovf_exp = ovf_pend;
        end
        #1;
        chk("busy", 32'(bus.busy), 32'(rem > 0));
        chk("done", 32'(bus.done), 32'(rem == 1));
        if (rem <= 1) begin
            c_act = cur_c();
            for (int n = 0; n < 9; n++) chk($sformatf("C[%0d]", n), c_act[n], c_exp[n]);
            chk("ovf", 32'(bus.ovf), 32'(ovf_exp));
        end
    end

    // Start one operation, optionally scramble inputs after acceptance, wait for done
    task automatic run_op(input mat_t a, input mat_t b, input bit garble,
                          output int lat, output int busy_cyc);
        @(negedge clk);
        drive_ab(a, b);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (garble) drive_ab(fill(32'hDEADBEEF), fill(32'h5A5A5A5A));
        lat      = 1;
        busy_cyc = bus.busy ? 1 : 0;
        while (!bus.done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.busy) busy_cyc++;
        end
        if (!bus.done) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout actual=no_done required=done_within_40");
        end
        @(posedge clk);
        #2;
    endtask

    initial begin
        mat_t ident, m, g;
        logic o;
        int   lat, bc, pulses;

        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        ident     = diag(32'h00010000, 32'h00010000, 32'h00010000);
        drive_ab('0, '0);

        // Model pinned against hand-computed values
        m = matmul(fill(32'h00018000), fill(32'hFFFE0000), o);
        chk("model_neg9", m[4], 32'hFFF70000);
        m = matmul(fill(32'h7FFF0000), fill(32'h00020000), o);
`ifdef MAT3_MUL_SAT_EN
        chk("model_sat", m[0], 32'h7FFFFFFF);
`else
        chk("model_wrap", m[0], 32'hFFFA0000);
`endif

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_C33", bus.C33, 32'h0);
        rst_n = 1'b1;

        // Identity x identity
        run_op(ident, ident, 1'b0, lat, bc);
        chk("id_latency", 32'(lat), 32'd28);
        chk("id_busy_cycles", 32'(bc), 32'd28);
        chk("id_C11", bus.C11, 32'h00010000);
        chk("id_C12", bus.C12, 32'h00000000);
        chk("id_after_busy", 32'(bus.busy), 32'h0);

        // Inverse self-check: diag(2,4,0.5) x diag(0.5,0.25,2)
        run_op(diag(32'h00020000, 32'h00040000, 32'h00008000),
               diag(32'h00008000, 32'h00004000, 32'h00020000), 1'b0, lat, bc);
        chk("inv_C22", bus.C22, 32'h00010000);
        chk("inv_C31", bus.C31, 32'h00000000);

        // 1.5 x -2.0 with inputs scrambled right after acceptance
        run_op(fill(32'h00018000), fill(32'hFFFE0000), 1'b1, lat, bc);
        chk("neg_C13", bus.C13, 32'hFFF70000);
        chk("neg_C32", bus.C32, 32'hFFF70000);

        // start held high: one operation every 29 cycles
        @(negedge clk);
        drive_ab(ident, ident);
        bus.start = 1'b1;
        pulses    = 0;
        for (int n = 0; n < 90; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) pulses++;
        end
        bus.start = 1'b0;
        chk("held_pulses", 32'(pulses), 32'd3);
        repeat (30) @(posedge clk);

        // Reset in the middle of a MAC sweep
        @(negedge clk);
        g = fill(32'h00018000);
        drive_ab(g, fill(32'hFFFE0000));
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort_busy", 32'(bus.busy), 32'h0);
        chk("abort_C11", bus.C11, 32'h0);
        pulses = 0;
        for (int n = 0; n < 35; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) pulses++;
        end
        chk("abort_no_done", 32'(pulses), 32'd0);
        run_op(ident, ident, 1'b0, lat, bc);
        chk("fresh_latency", 32'(lat), 32'd28);
        chk("fresh_C33", bus.C33, 32'h00010000);

        // Overflow vector
        @(negedge clk);
        drive_ab(fill(32'h7FFF0000), fill(32'h00020000));
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
`ifdef MAT3_MUL_SAT_EN
        chk("ovf_C21", bus.C21, 32'h7FFFFFFF);
        chk("ovf_flag", 32'(bus.ovf), 32'h1);
`else
        chk("wrap_C21", bus.C21, 32'hFFFA0000);
        chk("wrap_flag", 32'(bus.ovf), 32'h0);
`endif
        repeat (5) @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
